// File: rtl/nn_input_loader.sv
// Activation-input loader for ram_nn: takes one frame per inference from a valid/ready byte stream,
// writes it into the activation RAM, enforces frame length, then runs a four-phase req/ack handshake.
module nn_input_loader #(
    parameter int InputWidth = 49,
    parameter int DataWidth  = 8,
    parameter int AddrWidth  = (InputWidth > 1) ? $clog2(InputWidth) : 1,
    parameter int FrameCntW  = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic                 s_last_i,
    output logic                 actv_ram_we_o,
    output logic [AddrWidth-1:0] actv_ram_addr_o,
    output logic [DataWidth-1:0] actv_ram_din_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 len_err_o,
    output logic [FrameCntW-1:0] frame_cnt_o
);

    typedef enum logic [1:0] {LOAD, DRAIN, REQ, WAIT_LOW} state_t;

    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(InputWidth - 1);

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   count_q, count_d;
    logic                   we_q, we_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   din_q, din_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   len_err_q, len_err_d;
    logic [FrameCntW-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   beat;

    // Ready depends on state only so upstream never sees a valid->ready combinational path.
    assign s_ready_o = (state_q == LOAD) || (state_q == DRAIN);
    assign beat      = s_valid_i && s_ready_o;
    assign busy_o    = !((state_q == LOAD) && (count_q == '0));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            LOAD: begin
                if (beat) begin
                    we_d   = 1'b1;
                    addr_d = count_q;
                    din_d  = s_data_i;
                    if (count_q == LastIdx) begin
                        count_d = '0;
                        if (s_last_i) begin
                            state_d = REQ;
                        end else begin
                            len_err_d = 1'b1;
                            state_d   = DRAIN;
                        end
                    end else if (s_last_i) begin
                        // Short frame: already-written words are simply overwritten by the next frame.
                        len_err_d = 1'b1;
                        count_d   = '0;
                    end else begin
                        count_d = count_q + AddrWidth'(1);
                    end
                end
            end
            DRAIN: begin
                if (beat && s_last_i) state_d = REQ;
            end
            REQ: begin
                // Only an ack seen while our request is up completes the first handshake phase.
                if (req_q && ack_i) begin
                    state_d = WAIT_LOW;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!ack_i) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + FrameCntW'(1);
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= LOAD;
            count_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            req_q       <= req_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign actv_ram_we_o   = we_q;
    assign actv_ram_addr_o = addr_q;
    assign actv_ram_din_o  = din_q;
    assign req_o           = req_q;
    assign done_o          = done_q;
    assign len_err_o       = len_err_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule
